// File: rtl/gbe64_frame_sequencer.sv
// Frames 64-bit photon words into 10GbE UDP payloads: header word, payload, early close on idle timeout.
// Optional XOR trailer word when GBE64_SEQ_CHECKSUM_EN is defined.
module gbe64_frame_sequencer #(
    parameter int          MAX_WORDS     = 1024,
    parameter int          FLUSH_TIMEOUT = 2048,
    parameter logic [63:0] PAD_WORD      = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        user_clk,
    input  logic        user_rst,
    input  logic        enable,
    input  logic [31:0] words_per_frame,
    input  logic [7:0]  board_id,
    input  logic [39:0] timestamp,
    input  logic [63:0] fifo_dout,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic [63:0] tx_data,
    output logic        tx_valid,
    output logic        tx_end_of_frame,
    input  logic        tx_afull,
    output logic [15:0] frame_seq,
    output logic [15:0] timeout_count
);
    localparam int LW = $clog2(MAX_WORDS + 1);
    localparam int IW = $clog2(FLUSH_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PAYLOAD,
`ifdef GBE64_SEQ_CHECKSUM_EN
        S_TRAILER,
`endif
        S_PAD
    } state_t;

    state_t         state, state_next;
    logic [LW-1:0]  frame_len, len_q, cnt;
    logic [IW-1:0]  idle_cnt;
    logic           last_pop, idle_hit;
    logic           word_issue, word_eof, frame_done, frame_timeout;
    logic [63:0]    word_data, header;
`ifdef GBE64_SEQ_CHECKSUM_EN
    logic [63:0]    xor_acc;
    logic           pad_flag;
`endif

    always_comb begin
        if (words_per_frame == 32'd0)
            frame_len = LW'(1);
        else if (words_per_frame > 32'(MAX_WORDS))
            frame_len = LW'(MAX_WORDS);
        else
            frame_len = words_per_frame[LW-1:0];
    end

    assign header     = {board_id, frame_seq, timestamp};
    assign fifo_rd_en = (state == S_PAYLOAD) && !fifo_empty && !tx_afull;
    assign last_pop   = fifo_rd_en && (cnt == len_q - LW'(1));
    // Backpressure is not idleness: the idle counter only moves when the TX side could accept.
    assign idle_hit   = (state == S_PAYLOAD) && fifo_empty && !tx_afull &&
                        (idle_cnt == IW'(FLUSH_TIMEOUT - 1));

    always_ff @(posedge user_clk) begin
        if (user_rst)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:
                if (enable && !fifo_empty && !tx_afull) state_next = S_HDR;
            S_HDR:
                state_next = S_PAYLOAD;
            S_PAYLOAD:
`ifdef GBE64_SEQ_CHECKSUM_EN
                if (last_pop)      state_next = S_TRAILER;
`else
                if (last_pop)      state_next = S_IDLE;
`endif
                else if (idle_hit) state_next = S_PAD;
            S_PAD:
`ifdef GBE64_SEQ_CHECKSUM_EN
                if (!tx_afull) state_next = S_TRAILER;
            S_TRAILER:
                if (!tx_afull) state_next = S_IDLE;
`else
                if (!tx_afull) state_next = S_IDLE;
`endif
            default:
                state_next = S_IDLE;
        endcase
    end

    always_comb begin
        word_issue    = 1'b0;
        word_data     = 64'd0;
        word_eof      = 1'b0;
        frame_done    = 1'b0;
        frame_timeout = 1'b0;
        case (state)
            S_HDR: begin
                word_issue = 1'b1;
                word_data  = header;
            end
            S_PAYLOAD: begin
                if (fifo_rd_en) begin
                    word_issue = 1'b1;
                    word_data  = fifo_dout;
`ifndef GBE64_SEQ_CHECKSUM_EN
                    word_eof   = last_pop;
                    frame_done = last_pop;
`endif
                end
            end
            S_PAD: begin
                if (!tx_afull) begin
                    word_issue    = 1'b1;
                    word_data     = PAD_WORD;
`ifndef GBE64_SEQ_CHECKSUM_EN
                    word_eof      = 1'b1;
                    frame_done    = 1'b1;
                    frame_timeout = 1'b1;
`endif
                end
            end
`ifdef GBE64_SEQ_CHECKSUM_EN
            S_TRAILER: begin
                if (!tx_afull) begin
                    word_issue    = 1'b1;
                    word_data     = xor_acc;
                    word_eof      = 1'b1;
                    frame_done    = 1'b1;
                    frame_timeout = pad_flag;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            tx_data         <= 64'd0;
            tx_valid        <= 1'b0;
            tx_end_of_frame <= 1'b0;
            frame_seq       <= 16'd0;
            timeout_count   <= 16'd0;
            len_q           <= '0;
            cnt             <= '0;
            idle_cnt        <= '0;
        end else begin
            tx_valid        <= word_issue;
            tx_end_of_frame <= word_eof;
            if (word_issue)
                tx_data <= word_data;
            if (frame_done)
                frame_seq <= frame_seq + 16'd1;
            if (frame_timeout && (timeout_count != 16'hFFFF))
                timeout_count <= timeout_count + 16'd1;
            // Length is latched once per frame so register writes only affect the next frame.
            if (state == S_HDR) begin
                len_q    <= frame_len;
                cnt      <= '0;
                idle_cnt <= '0;
            end else if (fifo_rd_en) begin
                cnt      <= cnt + LW'(1);
                idle_cnt <= '0;
            end else if ((state == S_PAYLOAD) && fifo_empty && !tx_afull) begin
                idle_cnt <= idle_cnt + IW'(1);
            end
        end
    end

`ifdef GBE64_SEQ_CHECKSUM_EN
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            xor_acc  <= 64'd0;
            pad_flag <= 1'b0;
        end else if (state == S_HDR) begin
            xor_acc  <= header;
            pad_flag <= 1'b0;
        end else if (word_issue && (state != S_TRAILER)) begin
            xor_acc  <= xor_acc ^ word_data;
            if (state == S_PAD)
                pad_flag <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_gbe64_frame_sequencer.sv
// Self-checking bench for gbe64_frame_sequencer: FIFO model, expected-word scoreboard, summary line.
`timescale 1ns/1ps
module tb_gbe64_frame_sequencer;
    localparam int          MAXW  = 1024;
    localparam int          FLUSH = 2048;
    localparam logic [63:0] PADW  = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef GBE64_SEQ_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic        user_clk = 1'b0;
    logic        user_rst = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] words_per_frame = 32'd0;
    logic [7:0]  board_id = 8'd0;
    logic [39:0] timestamp = 40'd0;
    logic [63:0] fifo_dout = 64'd0;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd_en;
    logic [63:0] tx_data;
    logic        tx_valid;
    logic        tx_end_of_frame;
    logic        tx_afull = 1'b0;
    logic [15:0] frame_seq;
    logic [15:0] timeout_count;

    gbe64_frame_sequencer dut (
        .user_clk        (user_clk),
        .user_rst        (user_rst),
        .enable          (enable),
        .words_per_frame (words_per_frame),
        .board_id        (board_id),
        .timestamp       (timestamp),
        .fifo_dout       (fifo_dout),
        .fifo_empty      (fifo_empty),
        .fifo_rd_en      (fifo_rd_en),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_end_of_frame (tx_end_of_frame),
        .tx_afull        (tx_afull),
        .frame_seq       (frame_seq),
        .timeout_count   (timeout_count)
    );

    // clock / reset block
    always #5 user_clk = ~user_clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          prev_t = 0;
    logic [64:0] exp_q[$];
    logic [63:0] fq[$];
    logic [63:0] pend_data[$];
    logic [63:0] stage_q[$];
    int          gap_hist[$];
    logic [15:0] seq_m = 16'd0;
    logic [15:0] to_m = 16'd0;
    logic        pop_now = 1'b0;

    task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    always @(posedge user_clk) cyc <= cyc + 1;

    // FWFT FIFO model: pop decided mid-cycle, applied just after the edge
    always @(negedge user_clk) pop_now = fifo_rd_en && !user_rst;
    always @(posedge user_clk) begin
        #1;
        if (pop_now && fq.size() > 0) void'(fq.pop_front());
        fifo_empty = (fq.size() == 0);
        fifo_dout  = (fq.size() > 0) ? fq[0] : 64'd0;
    end

    // scoreboard monitor
    always @(negedge user_clk) begin
        logic [64:0] e;
        if (tx_end_of_frame) chk("eof_needs_valid", 65'(tx_valid), 65'd1);
        if (tx_valid) begin
            gap_hist.push_back(cyc - prev_t);
            prev_t = cyc;
            if (exp_q.size() == 0) begin
                chk("word_expected", 65'(exp_q.size()), 65'd1);
            end else begin
                e = exp_q.pop_front();
                chk("tx_word", {tx_end_of_frame, tx_data}, e);
            end
        end
    end

    // driver tasks
    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge user_clk);
            #2;
        end
    endtask

    function automatic int eff_len(input int unsigned w);
        return (w == 0) ? 1 : ((w > MAXW) ? MAXW : int'(w));
    endfunction

    task automatic gen_word(input logic [63:0] w);
        pend_data.push_back(w);
        stage_q.push_back(w);
    endtask

    task automatic gen_words(input int n);
        for (int i = 0; i < n; i++) gen_word({$urandom, $urandom});
    endtask

    task automatic feed(input int n);
        for (int i = 0; i < n; i++) fq.push_back(stage_q.pop_front());
    endtask

    task automatic load_words(input int n);
        gen_words(n);
        feed(n);
    endtask

    task automatic expect_frame(input int len, input int ndata);
        logic [63:0] x, w;
        x = {board_id, seq_m, timestamp};
        exp_q.push_back({1'b0, x});
        for (int i = 0; i < ndata; i++) begin
            w = pend_data.pop_front();
            x = x ^ w;
            exp_q.push_back({(i == len - 1) && !CK, w});
        end
        if (ndata < len) begin
            x = x ^ PADW;
            exp_q.push_back({!CK, PADW});
            if (to_m != 16'hFFFF) to_m++;
        end
        if (CK) exp_q.push_back({1'b1, x});
        seq_m++;
    endtask

    task automatic wait_size_le(input int n, input int budget);
        int t = 0;
        while (exp_q.size() > n && t < budget) begin
            cycles(1);
            t++;
        end
        if (exp_q.size() > n) chk("progress_timeout", 65'(exp_q.size()), 65'(n));
    endtask

    task automatic wait_drain(input int budget);
        int t = 0;
        while (exp_q.size() != 0 && t < budget) begin
            cycles(1);
            t++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", 65'(exp_q.size()), 65'd0);
            exp_q.delete();
        end
        cycles(3);
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_frame_seq"}, 65'(frame_seq), 65'(seq_m));
        chk({tag, "_timeout_count"}, 65'(timeout_count), 65'(to_m));
    endtask

    initial begin
        user_rst = 1'b1;
        cycles(3);
        chk("rst_tx_valid", 65'(tx_valid), 65'd0);
        chk("rst_tx_data", 65'(tx_data), 65'd0);
        chk("rst_eof", 65'(tx_end_of_frame), 65'd0);
        chk("rst_rd_en", 65'(fifo_rd_en), 65'd0);
        chk_counters("rst");
        user_rst = 1'b0;
        cycles(2);

        // two 4-word frames from 10 preloaded words, 2 left behind
        words_per_frame = 32'd4;
        board_id = 8'h2A;
        timestamp = 40'h01_2345_6789;
        load_words(10);
        expect_frame(4, 4);
        expect_frame(4, 4);
        enable = 1'b1;
        wait_size_le(4, 200);
        enable = 1'b0;
        wait_drain(200);
        chk_counters("len4");
        chk("fifo_left", 65'(fq.size()), 65'd2);
        fq.delete();
        pend_data.delete();
        cycles(2);

        // length 0 maps to 1, oversize clamps to MAX_WORDS
        words_per_frame = 32'd0;
        timestamp = 40'hAB_CDEF_0123;
        load_words(1);
        expect_frame(eff_len(0), 1);
        enable = 1'b1;
        wait_drain(100);
        words_per_frame = 32'd5000;
        load_words(MAXW);
        expect_frame(eff_len(5000), MAXW);
        wait_drain(3000);
        chk_counters("clamp");

        // idle timeout closes a partial frame with PAD
        words_per_frame = 32'd8;
        timestamp = 40'h00_0000_0042;
        load_words(3);
        expect_frame(8, 3);
        gap_hist.delete();
        wait_drain(2400);
        chk_counters("timeout");
        if (gap_hist.size() > 4) chk("pad_gap", 65'(gap_hist[4]), 65'(FLUSH + 1));
        else chk("pad_gap_count", 65'(gap_hist.size()), 65'd5);

        // backpressure mid-frame: no pops, no valid, order preserved
        words_per_frame = 32'd8;
        load_words(8);
        expect_frame(8, 8);
        wait_size_le(6, 200);
        tx_afull = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycles(1);
            chk("afull_valid", 65'(tx_valid), 65'd0);
            chk("afull_rd_en", 65'(fifo_rd_en), 65'd0);
        end
        tx_afull = 1'b0;
        wait_drain(200);
        chk_counters("afull");

        // backpressure during an idle stretch must not count toward the timeout
        words_per_frame = 32'd4;
        gen_words(4);
        expect_frame(4, 4);
        feed(2);
        cycles(2000);
        tx_afull = 1'b1;
        cycles(100);
        tx_afull = 1'b0;
        cycles(10);
        feed(2);
        wait_drain(200);
        chk_counters("idle_hold");

        // reset mid-frame aborts and restarts numbering
        words_per_frame = 32'd8;
        load_words(8);
        expect_frame(8, 8);
        wait_size_le(6, 200);
        user_rst = 1'b1;
        enable = 1'b0;
        cycles(1);
        chk("midrst_tx_valid", 65'(tx_valid), 65'd0);
        chk("midrst_tx_data", 65'(tx_data), 65'd0);
        chk("midrst_eof", 65'(tx_end_of_frame), 65'd0);
        chk("midrst_frame_seq", 65'(frame_seq), 65'd0);
        chk("midrst_timeout_count", 65'(timeout_count), 65'd0);
        user_rst = 1'b0;
        exp_q.delete();
        pend_data.delete();
        stage_q.delete();
        fq.delete();
        seq_m = 16'd0;
        to_m = 16'd0;
        cycles(2);
        load_words(8);
        expect_frame(8, 8);
        enable = 1'b1;
        wait_drain(200);
        chk_counters("after_rst");

        // small frame with known data (trailer = hdr^1^2 in checksum build)
        words_per_frame = 32'd2;
        board_id = 8'h5C;
        timestamp = 40'h12_3456_789A;
        gen_word(64'd1);
        gen_word(64'd2);
        expect_frame(2, 2);
        feed(2);
        wait_drain(100);
        chk_counters("known_data");

        cycles(5);
        chk("exp_q_empty", 65'(exp_q.size()), 65'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

endmodule
